// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-cycle-read data memory.
// Sub-word stores use read-modify-write; misaligned, illegal or out-of-range accesses fault without touching memory.
module load_store_unit #(
  parameter int BIT_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  // Request handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE; the response is a single resp_valid pulse with no back-pressure.
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [BIT_WIDTH-1:0]      req_wdata,
  output logic                      resp_valid,
  output logic [BIT_WIDTH-1:0]      resp_rdata,
  output logic                      resp_fault,
  output logic [MEM_ADDR_WIDTH-1:0] mem_readAddr,
  input  logic [BIT_WIDTH-1:0]      mem_readData,
  output logic [MEM_ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [BIT_WIDTH-1:0]      mem_writeData,
  output logic                      mem_writeEn,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [MEM_ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [BIT_WIDTH-1:0]      wdata_q, wdata_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [BIT_WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
  logic                      resp_fault_q, resp_fault_d;

  logic                      accept;
  logic                      f3_legal;
  logic                      misalign;
  logic                      out_of_range;
  logic                      req_fault;
  logic [4:0]                shamt;
  logic [BIT_WIDTH-1:0]      shifted;
  logic [BIT_WIDTH-1:0]      load_ext;
  logic [BIT_WIDTH-1:0]      lane_mask;
  logic [BIT_WIDTH-1:0]      merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    if (req_write) f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else           f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:MEM_ADDR_WIDTH+2];
  assign req_fault    = !f3_legal || misalign || out_of_range;

  // Byte lane arithmetic shared by load extraction and sub-word store merge.
  assign shamt   = {addr_q[1:0], 3'b000};
  assign shifted = mem_readData >> shamt;

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = mem_readData;
    endcase
  end

  assign lane_mask = (funct3_q[1:0] == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
  assign merged    = (mem_readData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          addr_d   = req_addr[MEM_ADDR_WIDTH+1:0];
          wdata_d  = req_wdata;
          if (req_fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (!req_write) begin
            state_d = S_LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end
      S_RMW_READ: begin
        // wdata_q becomes the full word to write back.
        wdata_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Reset gates the strobes combinationally so an in-flight write is dropped in its own cycle.
  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign resp_valid    = resp_valid_q && !rst;
  assign resp_rdata    = rst ? '0 : resp_rdata_q;
  assign resp_fault    = resp_fault_q && !rst;
  assign mem_writeEn   = (state_q == S_WRITE) && !rst;
  assign mem_readAddr  = addr_q[MEM_ADDR_WIDTH+1:2];
  assign mem_writeAddr = addr_q[MEM_ADDR_WIDTH+1:2];
  assign mem_writeData = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data memory, reference model with expected queue,
// directed scenarios followed by randomized requests.
module tb_load_store_unit;

  localparam int W = 33;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  mem_readAddr;
  logic [31:0] mem_readData;
  logic [7:0]  mem_writeAddr;
  logic [31:0] mem_writeData;
  logic        mem_writeEn;
  logic [2:0]  dbg_state;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int resp_count = 0;

  load_store_unit #(.BIT_WIDTH(32), .MEM_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_readAddr(mem_readAddr), .mem_readData(mem_readData),
    .mem_writeAddr(mem_writeAddr), .mem_writeData(mem_writeData),
    .mem_writeEn(mem_writeEn), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // data memory: asynchronous read, synchronous write
  assign mem_readData = mem[mem_readAddr];
  always @(posedge clk) begin
    if (mem_writeEn) begin
      mem[mem_writeAddr] <= mem_writeData;
      wr_count <= wr_count + 1;
    end
  end
  always @(negedge clk) if (resp_valid) resp_count <= resp_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model from the access rules; updates ref_mem for successful stores
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic flt, output logic [31:0] rd, output int lat, output int nw);
    int unsigned off, idx, nbytes;
    logic legal;
    logic [31:0] old, lo, v;
    off = a % 4;
    idx = (a / 4) % 256;
    legal = wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    flt = !legal || (a % nbytes != 0) || (a >= 32'd1024);
    rd = 32'h0;
    nw = 0;
    old = ref_mem[idx];
    lo = (nbytes == 1) ? 32'hFF : 32'hFFFF;
    if (flt) begin
      lat = 1;
    end else if (!wr) begin
      lat = 2;
      v = old >> (8 * off);
      if (nbytes != 4) begin
        v = v & lo;
        if (f3 < 4 && v > (lo >> 1)) v = v - (lo + 32'd1);
      end
      rd = v;
    end else begin
      nw = 1;
      if (nbytes == 4) begin
        lat = 2;
        ref_mem[idx] = wd;
      end else begin
        lat = 3;
        ref_mem[idx] = (old & ~(lo << (8 * off))) | ((wd & lo) << (8 * off));
      end
    end
  endtask

  // driver: one request, then response checks against the expected queue
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] obs_rd, output logic obs_flt, output int obs_lat);
    logic flt;
    logic [31:0] rd;
    int lat, nw, w0, idx;
    logic [W-1:0] exp;
    model(wr, f3, a, wd, flt, rd, lat, nw);
    exp_q.push_back({flt, rd});
    idx = int'((a / 4) % 256);
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1 check("ready_before_accept", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    obs_lat = 1;
    while (!resp_valid && obs_lat < 8) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_rd = resp_rdata;
    obs_flt = resp_fault;
    exp = exp_q.pop_front();
    check("latency", obs_lat, lat);
    check("response", {resp_fault, resp_rdata}, exp);
    check("write_strobes", wr_count - w0, nw);
    @(negedge clk);
    check("resp_cleared", {resp_valid, resp_fault, resp_rdata}, 34'h0);
    check("ready_after_resp", req_ready, 1'b1);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  initial begin
    logic [31:0] rd;
    logic flt;
    int lat, rc0, w0, nw;
    logic eflt;
    logic [31:0] erd;
    int elat;
    logic [31:0] a;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, resp_valid, resp_fault, mem_writeEn}, 4'b0);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_state", dbg_state, 3'd0);
    rst = 1'b0;
    #1 check("ready_after_reset", req_ready, 1'b1);

    // signed / unsigned byte loads
    set_word(5, 32'h8899AABB);
    do_req(1'b0, 3'b000, 32'h15, 32'h0, rd, flt, lat);
    check("lb_value", rd, 32'hFFFFFFAA);
    check("lb_latency", lat, 2);
    do_req(1'b0, 3'b100, 32'h15, 32'h0, rd, flt, lat);
    check("lbu_value", rd, 32'h000000AA);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, rd, flt, lat);
    check("lh_value", rd, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h16, 32'h0, rd, flt, lat);
    check("lhu_value", rd, 32'h00008899);

    // halfword read-modify-write
    set_word(5, 32'h11223344);
    w0 = wr_count;
    do_req(1'b1, 3'b001, 32'h16, 32'hDEADBEEF, rd, flt, lat);
    check("sh_mem", mem[5], 32'hBEEF3344);
    check("sh_latency", lat, 3);
    check("sh_one_strobe", wr_count - w0, 1);
    check("sh_rdata", {flt, rd}, 33'h0);

    // faults: misaligned, out of range, illegal funct3
    do_req(1'b0, 3'b010, 32'h102, 32'h0, rd, flt, lat);
    check("lw_misalign", {flt, rd}, {1'b1, 32'h0});
    check("lw_misalign_latency", lat, 1);
    w0 = wr_count;
    do_req(1'b1, 3'b010, 32'h400, 32'h55AA55AA, rd, flt, lat);
    check("sw_oor_fault", flt, 1'b1);
    check("sw_oor_no_write", wr_count - w0, 0);
    do_req(1'b1, 3'b100, 32'h24, 32'h77777777, rd, flt, lat);
    check("store_f3_100", flt, 1'b1);
    do_req(1'b0, 3'b011, 32'h24, 32'h0, rd, flt, lat);
    check("load_f3_011", flt, 1'b1);
    check("mem9_unchanged", mem[9], ref_mem[9]);

    // reset during the WRITE cycle of an SW
    set_word(8, 32'h01020304);
    rc0 = resp_count;
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("write_cycle_strobe", mem_writeEn, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_kills_strobe", mem_writeEn, 1'b0);
    check("rst_no_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst_falls", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_no_resp", resp_count - rc0, 0);
    check("rst_no_write", wr_count - w0, 0);
    check("rst_mem8", mem[8], 32'h01020304);

    // back-to-back SW then LW with req_valid held high
    model(1'b1, 3'b010, 32'h0, 32'h12345678, eflt, erd, elat, nw);
    model(1'b0, 3'b010, 32'h0, 32'h0, eflt, erd, elat, nw);
    exp_q.push_back({eflt, erd});
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_wdata = 32'h0;
    check("b2b_busy_write", req_ready, 1'b0);
    @(negedge clk);
    check("b2b_first_resp", {resp_valid, req_ready}, 2'b10);
    @(negedge clk);
    check("b2b_ready_after_resp", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_accepted", req_ready, 1'b0);
    @(negedge clk);
    check("b2b_lw_valid", resp_valid, 1'b1);
    check("b2b_lw_value", {resp_fault, resp_rdata}, exp_q.pop_front());
    check("b2b_lw_const", resp_rdata, 32'h12345678);
    @(negedge clk);

    // randomized requests
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 1023));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, flt, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
